// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue unit: ALUOp classes,
// 4-bit ALU operation codes, funct3 values and the decoder result struct.
`timescale 1ns/1ps
package alu_pkg;

  typedef enum logic [1:0] {
    LDST   = 2'b00,
    BRANCH = 2'b01,
    RTYPE  = 2'b10,
    ITYPE  = 2'b11
  } aluop_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_EQ  = 4'b1000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic [3:0] op;
    logic       invert;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational translation of ALUOp/funct3/funct7[5] into an ALU
// operation code plus the BNE invert flag and an illegal-encoding flag.
`timescale 1ns/1ps
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output decode_t    dec
);

  aluop_t aluop_e;
  assign aluop_e = aluop_t'(aluop);

  always_comb begin
    dec.op      = OP_AND;
    dec.invert  = 1'b0;
    dec.illegal = 1'b0;
    case (aluop_e)
      LDST: dec.op = OP_ADD;
      BRANCH: begin
        case (funct3)
          F3_BEQ: dec.op = OP_EQ;
          F3_BNE: begin
            dec.op     = OP_EQ;
            dec.invert = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      RTYPE, ITYPE: begin
        case (funct3)
          // funct7[5] selects SUB only for register-register ops; ADDI ignores it
          F3_ADD:  dec.op = (aluop_e == RTYPE && funct7b5) ? OP_SUB : OP_ADD;
          F3_AND:  dec.op = OP_AND;
          F3_OR:   dec.op = OP_OR;
          F3_XOR:  dec.op = OP_XOR;
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue/result pipeline in front of a combinational ALU:
// S1 drives the ALU ports, S2 captures the result for the consumer.
`timescale 1ns/1ps
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_aluop,
  input  logic [2:0]               in_funct3,
  input  logic                     in_funct7b5,
  input  logic [DATA_WIDTH-1:0]    in_a,
  input  logic [DATA_WIDTH-1:0]    in_b,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_result,
  output logic                     out_illegal
);

  decode_t dec;

  logic                     s1_valid_reg;
  logic [DATA_WIDTH-1:0]    s1_srca_reg;
  logic [DATA_WIDTH-1:0]    s1_srcb_reg;
  logic [OPCODE_LENGTH-1:0] s1_op_reg;
  logic                     s1_invert_reg;
  logic                     s1_illegal_reg;

  logic                     s2_valid_reg;
  logic [DATA_WIDTH-1:0]    s2_result_reg;
  logic                     s2_illegal_reg;

  logic                     s1_free;
  logic                     s2_free;
  logic                     in_fire;
  logic                     s1_to_s2;
  logic [DATA_WIDTH-1:0]    result_next;

  alu_op_decode u_decode (
    .aluop    (in_aluop),
    .funct3   (in_funct3),
    .funct7b5 (in_funct7b5),
    .dec      (dec)
  );

  assign s2_free  = !s2_valid_reg || out_ready;
  assign s1_free  = !s1_valid_reg || s2_free;
  assign in_ready = s1_free;
  assign in_fire  = in_valid && s1_free;
  assign s1_to_s2 = s1_valid_reg && s2_free;

  // BNE reuses the EQ compare and flips its single-bit outcome
  assign result_next = s1_invert_reg ? {{(DATA_WIDTH-1){1'b0}}, ~alu_result[0]}
                                     : alu_result;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg   <= 1'b0;
      s1_srca_reg    <= '0;
      s1_srcb_reg    <= '0;
      s1_op_reg      <= '0;
      s1_invert_reg  <= 1'b0;
      s1_illegal_reg <= 1'b0;
    end else if (in_fire) begin
      s1_valid_reg   <= 1'b1;
      s1_srca_reg    <= dec.illegal ? '0 : in_a;
      s1_srcb_reg    <= dec.illegal ? '0 : in_b;
      s1_op_reg      <= OPCODE_LENGTH'(dec.op);
      s1_invert_reg  <= dec.invert;
      s1_illegal_reg <= dec.illegal;
    end else if (s2_free) begin
      s1_valid_reg   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_reg   <= 1'b0;
      s2_result_reg  <= '0;
      s2_illegal_reg <= 1'b0;
    end else if (s1_to_s2) begin
      s2_valid_reg   <= 1'b1;
      s2_result_reg  <= result_next;
      s2_illegal_reg <= s1_illegal_reg;
    end else if (out_ready) begin
      s2_valid_reg   <= 1'b0;
    end
  end

  assign alu_srca      = s1_srca_reg;
  assign alu_srcb      = s1_srcb_reg;
  assign alu_operation = s1_op_reg;
  assign out_valid     = s2_valid_reg;
  assign out_result    = s2_result_reg;
  assign out_illegal   = s2_illegal_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural combinational ALU
// hooked to the alu_* ports and hand-computed expected results.
`timescale 1ns/1ps
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_aluop      (in_aluop),
    .in_funct3     (in_funct3),
    .in_funct7b5   (in_funct7b5),
    .in_a          (in_a),
    .in_b          (in_b),
    .alu_srca      (alu_srca),
    .alu_srcb      (alu_srcb),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_illegal   (out_illegal)
  );

  // External ALU model
  always_comb begin
    alu_result = '0;
    case (alu_operation)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca - alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0011: alu_result = alu_srca | alu_srcb;
      4'b0100: alu_result = alu_srca ^ alu_srcb;
      4'b1000: alu_result = {31'b0, alu_srca == alu_srcb};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b);
    in_aluop    = op;
    in_funct3   = f3;
    in_funct7b5 = f7;
    in_a        = a;
    in_b        = b;
  endtask

  // Present one request and return one sample point after the accepting edge
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b);
    int n;
    drive(op, f3, f7, a, b);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic single(input string tag, input logic [1:0] op, input logic [2:0] f3,
                        input logic f7, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] exp_op, input logic [31:0] exp_res,
                        input logic exp_ill);
    send(op, f3, f7, a, b);
    chk({tag, "_op"},   {28'b0, alu_operation}, {28'b0, exp_op});
    chk({tag, "_srca"}, alu_srca, exp_ill ? 32'd0 : a);
    chk({tag, "_srcb"}, alu_srcb, exp_ill ? 32'd0 : b);
    tick();
    chk({tag, "_valid"},   {31'b0, out_valid},   32'd1);
    chk({tag, "_result"},  out_result,           exp_res);
    chk({tag, "_illegal"}, {31'b0, out_illegal}, {31'b0, exp_ill});
    $display("txn %-10s result=%h illegal=%0b", tag, out_result, out_illegal);
    tick();
    chk({tag, "_once"}, {31'b0, out_valid}, 32'd0);
  endtask

  logic [1:0]  tp_op  [8] = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2};
  logic [2:0]  tp_f3  [8] = '{3'd7, 3'd6, 3'd4, 3'd7, 3'd6, 3'd4, 3'd4, 3'd7};
  logic [31:0] tp_a   [8] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h12345678,
                              32'h12340000, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'hAAAAAAAA};
  logic [31:0] tp_b   [8] = '{32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0000FFFF,
                              32'h00005678, 32'h0000000F, 32'h55555555, 32'h55555555};
  logic [31:0] tp_exp [8] = '{32'h0F000F00, 32'hFF0FFF0F, 32'hF00FF00F, 32'h00005678,
                              32'h12345678, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h00000000};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int i;
    int got;
    logic acc;
    logic dlv;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(2'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    repeat (3) tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_op",        {28'b0, alu_operation}, 32'd0);
    chk("rst_result",    out_result, 32'd0);
    chk("rst_illegal",   {31'b0, out_illegal}, 32'd0);
    reset_n = 1'b1;
    tick();

    single("sub",      2'd2, 3'd0, 1'b1, 32'd5, 32'd7, 4'b0001, 32'hFFFFFFFE, 1'b0);
    single("add",      2'd2, 3'd0, 1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
    single("addi_f7",  2'd3, 3'd0, 1'b1, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
    single("ldst",     2'd0, 3'd2, 1'b1, 32'd100, 32'd8, 4'b0010, 32'd108, 1'b0);
    single("beq",      2'd1, 3'd0, 1'b0, 32'h1234, 32'h1234, 4'b1000, 32'd1, 1'b0);
    single("bne_eq",   2'd1, 3'd1, 1'b0, 32'h1234, 32'h1234, 4'b1000, 32'd0, 1'b0);
    single("bne_ne",   2'd1, 3'd1, 1'b0, 32'd1, 32'd2, 4'b1000, 32'd1, 1'b0);
    single("ill_r001", 2'd2, 3'd1, 1'b0, 32'hDEAD, 32'hBEEF, 4'b0000, 32'd0, 1'b1);
    single("ill_b100", 2'd1, 3'd4, 1'b0, 32'd5, 32'd5, 4'b0000, 32'd0, 1'b1);
    single("ill_i010", 2'd3, 3'd2, 1'b0, 32'hFFFF, 32'hFFFF, 4'b0000, 32'd0, 1'b1);

    // Backpressure: 4 ADDI requests, consumer stalled for the first 5 cycles
    i   = 0;
    got = 0;
    drive(2'd3, 3'd0, 1'b0, 32'd0, 32'd10);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      out_ready = (c >= 5);
      #1;
      if (c >= 2 && c <= 4) begin
        chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_result", out_result, 32'd10);
        chk("bp_hold_srca",   alu_srca, 32'd1);
      end
      if (c == 2) chk("bp_accepts", i, 32'd2);
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      if (dlv) begin
        chk("bp_result", out_result, 32'd10 + got);
        $display("txn bp%0d      result=%h", got, out_result);
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        if (i < 4) drive(2'd3, 3'd0, 1'b0, i, 32'd10);
        else in_valid = 1'b0;
      end
    end
    chk("bp_count", got, 32'd4);
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Throughput: 8 back-to-back logic ops with the consumer always ready
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        drive(tp_op[c], tp_f3[c], 1'b0, tp_a[c], tp_b[c]);
        in_valid = 1'b1;
        chk("tp_in_ready", {31'b0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      if (c >= 2) begin
        chk("tp_valid",  {31'b0, out_valid}, 32'd1);
        chk("tp_result", out_result, tp_exp[c-2]);
        $display("txn tp%0d      result=%h", c - 2, out_result);
      end
      tick();
    end
    chk("tp_drained", {31'b0, out_valid}, 32'd0);

    // Mid-stream asynchronous reset with two requests in flight
    out_ready = 1'b0;
    drive(2'd2, 3'd0, 1'b0, 32'd3, 32'd4);
    in_valid = 1'b1;
    tick();
    drive(2'd2, 3'd0, 1'b1, 32'd9, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("mr_pre_valid", {31'b0, out_valid}, 32'd1);
    chk("mr_pre_op",    {28'b0, alu_operation}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_in_ready",  {31'b0, in_ready}, 32'd1);
    chk("mr_op",        {28'b0, alu_operation}, 32'd0);
    chk("mr_result",    out_result, 32'd0);
    tick();
    out_ready = 1'b1;
    reset_n   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mr_no_delivery", {31'b0, out_valid}, 32'd0);
    end
    single("post_rst", 2'd3, 3'd0, 1'b0, 32'd20, 32'd22, 4'b0010, 32'd42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
